// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, coordinate widths and the write-arbiter state type.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 640;
    localparam int unsigned FB_HEIGHT = 480;
    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;
    localparam int unsigned COLOR_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } fb_arb_state_t;

endpackage

// File: rtl/fb_raster_counter.sv
// Enable-gated x/y raster-order counter with synchronous zero and a last-pixel flag.
module fb_raster_counter
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH  = FB_WIDTH,
    parameter int unsigned HEIGHT = FB_HEIGHT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic           zero_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (zero_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en_i) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Single write port of the back buffer: rasterizer pixels in IDLE, full-screen clear fill in CLEAR.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH   = FB_WIDTH,
    parameter int unsigned HEIGHT  = FB_HEIGHT,
    parameter int unsigned COLOR_W = fb_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    input  logic               rast_valid,
    input  logic [X_W-1:0]     rast_x,
    input  logic [Y_W-1:0]     rast_y,
    input  logic [COLOR_W-1:0] rast_color,
    output logic               rast_ready,
    input  logic               fb_write_allow,
    output logic               wr_en,
    output logic [X_W-1:0]     wr_x,
    output logic [Y_W-1:0]     wr_y,
    output logic [COLOR_W-1:0] wr_color,
    output logic               clear_busy,
    output logic               clear_done,
    output logic               rast_drop
);

    fb_arb_state_t      state_q;
    logic               wr_en_q;
    logic [X_W-1:0]     wr_x_q;
    logic [Y_W-1:0]     wr_y_q;
    logic [COLOR_W-1:0] wr_color_q;
    logic [COLOR_W-1:0] clear_color_q;
    logic               clear_busy_q;
    logic               clear_done_q;
    logic               rast_drop_q;

    logic               cnt_en;
    logic               cnt_zero;
    logic [X_W-1:0]     cx;
    logic [Y_W-1:0]     cy;
    logic               cnt_last;
    logic               pix_on_screen;

    assign rast_ready    = (state_q == IDLE) && fb_write_allow && !clear_req;
    assign pix_on_screen = (32'(rast_x) < WIDTH) && (32'(rast_y) < HEIGHT);
    assign cnt_en        = (state_q == CLEAR) && fb_write_allow;
    assign cnt_zero      = (state_q == IDLE) && clear_req;

    fb_raster_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_clear_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (cnt_en),
        .zero_i(cnt_zero),
        .x_o   (cx),
        .y_o   (cy),
        .last_o(cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_en_q       <= 1'b0;
            wr_x_q        <= '0;
            wr_y_q        <= '0;
            wr_color_q    <= '0;
            clear_color_q <= '0;
            clear_busy_q  <= 1'b0;
            clear_done_q  <= 1'b0;
            rast_drop_q   <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            rast_drop_q  <= 1'b0;
            clear_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        clear_color_q <= clear_color;
                        clear_busy_q  <= 1'b1;
                        state_q       <= CLEAR;
                    end else if (rast_valid && rast_ready) begin
                        if (pix_on_screen) begin
                            wr_en_q    <= 1'b1;
                            wr_x_q     <= rast_x;
                            wr_y_q     <= rast_y;
                            wr_color_q <= rast_color;
                        end else begin
                            rast_drop_q <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (fb_write_allow) begin
                        wr_en_q    <= 1'b1;
                        wr_x_q     <= cx;
                        wr_y_q     <= cy;
                        wr_color_q <= clear_color_q;
                        if (cnt_last) state_q <= DONE;
                    end
                end
                DONE: begin
                    clear_done_q <= 1'b1;
                    clear_busy_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_x       = wr_x_q;
    assign wr_y       = wr_y_q;
    assign wr_color   = wr_color_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;
    assign rast_drop  = rast_drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized and directed bench for fb_write_arbiter against a linear-pixel-index reference model.
module tb_fb_write_arbiter;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 12;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic [CW-1:0] clear_color;
    logic          rast_valid;
    logic [9:0]    rast_x;
    logic [8:0]    rast_y;
    logic [CW-1:0] rast_color;
    logic          rast_ready;
    logic          fb_write_allow;
    logic          wr_en;
    logic [9:0]    wr_x;
    logic [8:0]    wr_y;
    logic [CW-1:0] wr_color;
    logic          clear_busy;
    logic          clear_done;
    logic          rast_drop;

    always #5 clk = ~clk;

    fb_write_arbiter #(
        .WIDTH  (W),
        .HEIGHT (H),
        .COLOR_W(CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear_req     (clear_req),
        .clear_color   (clear_color),
        .rast_valid    (rast_valid),
        .rast_x        (rast_x),
        .rast_y        (rast_y),
        .rast_color    (rast_color),
        .rast_ready    (rast_ready),
        .fb_write_allow(fb_write_allow),
        .wr_en         (wr_en),
        .wr_x          (wr_x),
        .wr_y          (wr_y),
        .wr_color      (wr_color),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .rast_drop     (rast_drop)
    );

    int n_checks = 0;
    int n_errors = 0;
    int wr_obs   = 0;
    int done_obs = 0;

    // Reference model: phase 0 = serving pixels, 1 = filling, 2 = fill finished, done pending.
    // m_pos is the linear pixel index of the next fill write.
    int            m_phase = 0;
    int            m_pos   = 0;
    logic [CW-1:0] m_color = '0;
    logic          m_busy  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pos   = 0;
        m_color = '0;
        m_busy  = 1'b0;
    endtask

    // Called at a negedge; drives one cycle of stimulus, checks, and returns at the next negedge.
    task automatic cycle(input logic v, input int x, input int y, input logic [CW-1:0] c,
                         input logic creq, input logic [CW-1:0] ccol, input logic allow);
        logic          e_ready, e_wr, e_drop, e_done;
        int            ex, ey;
        logic [CW-1:0] ec;
        rast_valid     = v;
        rast_x         = 10'(x);
        rast_y         = 9'(y);
        rast_color     = c;
        clear_req      = creq;
        clear_color    = ccol;
        fb_write_allow = allow;
        #1;
        e_ready = (m_phase == 0) && allow && !creq;
        check("rast_ready", {31'b0, rast_ready}, {31'b0, e_ready});

        e_wr = 1'b0; e_drop = 1'b0; e_done = 1'b0;
        ex = 0; ey = 0; ec = '0;
        if (m_phase == 0) begin
            if (creq) begin
                m_color = ccol;
                m_pos   = 0;
                m_phase = 1;
                m_busy  = 1'b1;
            end else if (v && allow) begin
                if (x < int'(W) && y < int'(H)) begin
                    e_wr = 1'b1; ex = x; ey = y; ec = c;
                end else begin
                    e_drop = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            if (allow) begin
                e_wr = 1'b1;
                ex = m_pos % int'(W);
                ey = m_pos / int'(W);
                ec = m_color;
                m_pos++;
                if (m_pos == int'(W * H)) m_phase = 2;
            end
        end else begin
            e_done  = 1'b1;
            m_busy  = 1'b0;
            m_phase = 0;
        end

        @(posedge clk);
        #1;
        check("wr_en", {31'b0, wr_en}, {31'b0, e_wr});
        if (e_wr) begin
            check("wr_x", {22'b0, wr_x}, 32'(ex));
            check("wr_y", {23'b0, wr_y}, 32'(ey));
            check("wr_color", {29'b0, wr_color}, {29'b0, ec});
        end
        check("rast_drop", {31'b0, rast_drop}, {31'b0, e_drop});
        check("clear_done", {31'b0, clear_done}, {31'b0, e_done});
        check("clear_busy", {31'b0, clear_busy}, {31'b0, m_busy});
        if (wr_en) wr_obs++;
        if (clear_done) done_obs++;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 0, 0, '0, 1'b0, '0, 1'b1);
    endtask

    // Asserted at a negedge so outputs are checked with no clock edge in between.
    task automatic do_reset();
        rst            = 1'b1;
        clear_req      = 1'b0;
        rast_valid     = 1'b0;
        fb_write_allow = 1'b1;
        #1;
        check("rst_wr_en", {31'b0, wr_en}, 32'd0);
        check("rst_wr_x", {22'b0, wr_x}, 32'd0);
        check("rst_wr_y", {23'b0, wr_y}, 32'd0);
        check("rst_wr_color", {29'b0, wr_color}, 32'd0);
        check("rst_clear_busy", {31'b0, clear_busy}, 32'd0);
        check("rst_clear_done", {31'b0, clear_done}, 32'd0);
        check("rst_rast_drop", {31'b0, rast_drop}, 32'd0);
        check("rst_rast_ready", {31'b0, rast_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic finish_clear(input string tag, input int exp_writes);
        for (int i = 0; i < int'(4 * W * H) && m_phase != 0; i++) idle_cycle();
        check({tag, "_bounded"}, 32'(m_phase), 32'd0);
        check({tag, "_writes"}, 32'(wr_obs), 32'(exp_writes));
        check({tag, "_done_cnt"}, 32'(done_obs), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        clear_req      = 1'b0;
        clear_color    = '0;
        rast_valid     = 1'b0;
        rast_x         = '0;
        rast_y         = '0;
        rast_color     = '0;
        fb_write_allow = 1'b1;
        @(negedge clk);
        do_reset();

        // Back-to-back pixels, including the far corner, then off-screen drops.
        cycle(1'b1, 5, 7, 3'd3, 1'b0, '0, 1'b1);
        cycle(1'b1, W - 1, H - 1, 3'd1, 1'b0, '0, 1'b1);
        cycle(1'b1, 0, 0, 3'd7, 1'b0, '0, 1'b1);
        cycle(1'b1, W, 10, 3'd4, 1'b0, '0, 1'b1);
        cycle(1'b1, 3, H, 3'd5, 1'b0, '0, 1'b1);
        idle_cycle();

        // Full clear, with a pixel offered alongside the request.
        wr_obs = 0; done_obs = 0;
        cycle(1'b1, 1, 1, 3'd6, 1'b1, 3'd2, 1'b1);
        finish_clear("clear_full", W * H);
        idle_cycle();

        // Clear stalled for 10 cycles at (5,3) plus a second ignored request.
        wr_obs = 0; done_obs = 0;
        cycle(1'b0, 0, 0, '0, 1'b1, 3'd5, 1'b1);
        while (m_pos < int'(3 * W + 5)) idle_cycle();
        for (int i = 0; i < 10; i++) cycle(1'b1, 2, 2, 3'd1, 1'b0, '0, 1'b0);
        cycle(1'b1, 4, 4, 3'd3, 1'b1, 3'd6, 1'b1);
        finish_clear("clear_stall", W * H);

        // Randomized traffic, occasional clears and write-allow stalls.
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, W + 3)),
                  int'($urandom_range(0, H + 3)), 3'($urandom),
                  ($urandom_range(0, 59) == 0), 3'($urandom),
                  ($urandom_range(0, 7) != 0));
        end
        for (int i = 0; i < int'(4 * W * H) && m_phase != 0; i++) idle_cycle();

        // Reset part-way through a clear: abandon it, no done pulse afterwards.
        idle_cycle();
        cycle(1'b0, 0, 0, '0, 1'b1, 3'd4, 1'b1);
        while (m_pos < int'(8 * W)) idle_cycle();
        done_obs = 0;
        do_reset();
        cycle(1'b1, 2, 2, 3'd6, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) idle_cycle();
        check("rst_no_done", 32'(done_obs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
